// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: steps a 2-to-4 decoder select through unmasked channels with a fixed dwell
module decoder_scan_sequencer #(
    parameter int DWELL = 100,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       one_shot,
    input  logic [3:0] skip_mask,
    output logic [1:0] Din,
    output logic       En,
    output logic       busy,
    output logic       sweep_done
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_mask, w_mask_nxt;
    logic             r_one_shot, w_one_shot_nxt;
    logic [1:0]       r_din, w_din_nxt;
    logic             r_en, r_busy, r_done, w_done_nxt;
    logic [1:0]       w_first, w_wrap, w_up;
    logic             w_above, w_start_ok, w_expire, w_finish;
    assign Din        = r_din;
    assign En         = r_en;
    assign busy       = r_busy;
    assign sweep_done = r_done;
    assign w_start_ok = start && !stop && (skip_mask != 4'b1111);
    assign w_expire   = (r_cnt == CNT_W'(DWELL - 1));
    assign w_finish   = w_expire && r_one_shot && !w_above;
    // channel search: lowest unmasked in the incoming mask, lowest and next-above in the captured mask
    always_comb begin
        w_first = 2'd0;
        w_wrap  = 2'd0;
        w_up    = 2'd0;
        w_above = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!skip_mask[i]) w_first = 2'(i);
            if (!r_mask[i]) w_wrap = 2'(i);
            if (!r_mask[i] && (2'(i) > r_din)) begin
                w_up    = 2'(i);
                w_above = 1'b1;
            end
        end
    end
    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_mask     <= 4'b0000;
            r_one_shot <= 1'b0;
            r_din      <= 2'b00;
            r_en       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_mask     <= w_mask_nxt;
            r_one_shot <= w_one_shot_nxt;
            r_din      <= w_din_nxt;
            r_en       <= (w_state_nxt == RUN);
            r_busy     <= (w_state_nxt == RUN);
            r_done     <= w_done_nxt;
        end
    end
    // next state: stop beats both start and dwell expiry
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == IDLE) w_state_nxt = w_start_ok ? RUN : IDLE;
        else w_state_nxt = (stop || w_finish) ? IDLE : RUN;
    end
    // next outputs and captured configuration
    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_mask_nxt     = r_mask;
        w_one_shot_nxt = r_one_shot;
        w_din_nxt      = r_din;
        w_done_nxt     = 1'b0;
        if (r_state == IDLE) begin
            if (w_start_ok) begin
                w_cnt_nxt      = '0;
                w_mask_nxt     = skip_mask;
                w_one_shot_nxt = one_shot;
                w_din_nxt      = w_first;
            end
        end else if (stop) begin
            w_cnt_nxt = '0;
        end else if (w_expire) begin
            w_cnt_nxt  = '0;
            w_done_nxt = w_finish;
            w_din_nxt  = w_finish ? r_din : (w_above ? w_up : w_wrap);
        end else begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb_decoder_scan_sequencer: directed vectors for three dwell settings sharing one stimulus
module tb_decoder_scan_sequencer;
    logic clk = 0, rst = 1, start = 0, stop = 0, one_shot = 0;
    logic [3:0] skip_mask = 0;
    logic [1:0] din_a, din_b, din_c;
    logic en_a, en_b, en_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;
    int total = 0, bad = 0;
    typedef struct {
        logic start, stop, os;
        logic [3:0] mask;
        logic [1:0] din;
        logic en, busy, done;
    } vec_t;
    vec_t tv[22];
    always #5 clk = ~clk;
    decoder_scan_sequencer #(.DWELL(4), .CNT_W(16)) u_a (.clk(clk), .rst(rst), .start(start), .stop(stop),
        .one_shot(one_shot), .skip_mask(skip_mask), .Din(din_a), .En(en_a), .busy(busy_a), .sweep_done(done_a));
    decoder_scan_sequencer #(.DWELL(2), .CNT_W(16)) u_b (.clk(clk), .rst(rst), .start(start), .stop(stop),
        .one_shot(one_shot), .skip_mask(skip_mask), .Din(din_b), .En(en_b), .busy(busy_b), .sweep_done(done_b));
    decoder_scan_sequencer #(.DWELL(1), .CNT_W(16)) u_c (.clk(clk), .rst(rst), .start(start), .stop(stop),
        .one_shot(one_shot), .skip_mask(skip_mask), .Din(din_c), .En(en_c), .busy(busy_c), .sweep_done(done_c));
    task automatic step(input logic s, input logic p, input logic o, input logic [3:0] m);
        start = s;
        stop = p;
        one_shot = o;
        skip_mask = m;
        @(posedge clk);
        #1;
    endtask
    // exp packs {Din, En, busy, sweep_done}
    task automatic chk(input string nm, input int sel, input logic [4:0] exp);
        logic [4:0] got;
        got = (sel == 0) ? {din_a, en_a, busy_a, done_a} :
              (sel == 1) ? {din_b, en_b, busy_b, done_b} : {din_c, en_c, busy_c, done_c};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got {Din,En,busy,done}=%b expected %b", nm, got, exp);
        end
    endtask
    initial begin
        for (int k = 0; k < 22; k++) begin
            tv[k].start = (k == 0);
            tv[k].stop  = (k == 21);
            tv[k].os    = 1'b0;
            tv[k].mask  = 4'b0000;
            tv[k].din   = 2'((k / 4) % 4);
            tv[k].en    = (k != 21);
            tv[k].busy  = (k != 21);
            tv[k].done  = 1'b0;
        end
        rst = 1;
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 4'b0000);
            chk("reset_a", 0, 5'b00000);
            chk("reset_b", 1, 5'b00000);
            chk("reset_c", 2, 5'b00000);
        end
        rst = 0;
        step(0, 0, 0, 4'b0000);
        chk("idle_after_reset", 0, 5'b00000);
        for (int k = 0; k < 22; k++) begin
            step(tv[k].start, tv[k].stop, tv[k].os, tv[k].mask);
            chk($sformatf("scan_vec%0d", k), 0, {tv[k].din, tv[k].en, tv[k].busy, tv[k].done});
        end
        step(1, 0, 1, 4'b0101);
        chk("oneshot_d1_c1", 1, 5'b01110);
        step(0, 0, 0, 4'b1111);
        chk("oneshot_d1_c2", 1, 5'b01110);
        step(0, 0, 0, 4'b0000);
        chk("oneshot_d3_c1", 1, 5'b11110);
        step(0, 0, 0, 4'b0000);
        chk("oneshot_d3_c2", 1, 5'b11110);
        step(0, 0, 0, 4'b0000);
        chk("oneshot_done", 1, 5'b11001);
        step(0, 0, 0, 4'b0000);
        chk("oneshot_done_clear", 1, 5'b11000);
        repeat (8) step(0, 0, 0, 4'b0000);
        chk("oneshot_a_idle", 0, 5'b11000);
        step(1, 0, 0, 4'b0000);
        repeat (10) step(0, 0, 0, 4'b0000);
        chk("stop_pre_din2", 0, 5'b10110);
        step(0, 1, 0, 4'b0000);
        chk("stop_din_hold", 0, 5'b10000);
        step(0, 0, 0, 4'b0000);
        chk("stop_stays_idle", 0, 5'b10000);
        step(1, 0, 0, 4'b0001);
        chk("restart_lowest", 0, 5'b01110);
        step(0, 1, 0, 4'b0000);
        chk("restart_stop", 0, 5'b01000);
        step(1, 0, 0, 4'b1111);
        chk("all_masked_ignored", 0, 5'b01000);
        step(1, 1, 0, 4'b0000);
        chk("start_stop_idle", 0, 5'b01000);
        step(1, 0, 0, 4'b0000);
        chk("expiry_start", 0, 5'b00110);
        repeat (3) step(0, 0, 0, 4'b0000);
        chk("expiry_last_cycle", 0, 5'b00110);
        step(0, 1, 0, 4'b0000);
        chk("stop_at_expiry", 0, 5'b00000);
        step(1, 0, 0, 4'b0000);
        chk("dwell1_c0", 2, 5'b00110);
        for (int k = 1; k < 5; k++) begin
            step(0, 0, 0, 4'b0000);
            chk($sformatf("dwell1_step%0d", k), 2, {2'(k % 4), 3'b110});
        end
        rst = 1;
        step(0, 0, 0, 4'b0000);
        chk("midrun_reset_c", 2, 5'b00000);
        chk("midrun_reset_a", 0, 5'b00000);
        rst = 0;
        step(0, 0, 0, 4'b0000);
        chk("post_reset_idle", 2, 5'b00000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
